// File: rtl/test_sequencer.sv
// Test-vector sequencer: walks a vector ROM and drives each entry to the DUT over valid/ready.
// Optional watchdog on stalled vectors is enabled by defining TEST_SEQ_TIMEOUT_EN.
module test_sequencer #(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned NUM_TESTS      = 12,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  stim_valid,
  output logic [DATA_WIDTH-1:0] stim_data,
  input  logic                  stim_ready,
  output logic [ADDR_WIDTH-1:0] test,
  output logic                  busy,
  output logic                  done
`ifdef TEST_SEQ_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_DRIVE = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_TESTS - 1);

  // Reject configurations that would wrap the index or never terminate a stalled vector
  if (NUM_TESTS < 1 || NUM_TESTS > (2 ** ADDR_WIDTH) || TIMEOUT_CYCLES == 0) begin : g_bad_param
    $error("test_sequencer: illegal NUM_TESTS/ADDR_WIDTH/TIMEOUT_CYCLES combination");
  end

  logic [2:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_test;
  logic [DATA_WIDTH-1:0] r_stim_data;
  logic                  r_stim_valid;
  logic                  r_busy;
  logic                  r_done;
  logic [GAP_W-1:0]      r_gap_cnt;

  logic [2:0]            w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_test_nxt;
  logic [DATA_WIDTH-1:0] w_data_nxt;
  logic [GAP_W-1:0]      w_gap_nxt;
  logic                  w_hs;
  logic                  w_advance;

`ifdef TEST_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            r_timeout_err;
  logic [WD_W-1:0] w_wd_nxt;
  logic            w_err_nxt;
  logic            w_timeout;
`endif

  // Next-state and next-register decode
  always_comb begin
    w_state_nxt = r_state;
    w_test_nxt  = r_test;
    w_data_nxt  = r_stim_data;
    w_gap_nxt   = r_gap_cnt;
    w_hs        = r_stim_valid & stim_ready;
    w_advance   = 1'b0;
`ifdef TEST_SEQ_TIMEOUT_EN
    w_wd_nxt    = r_wd_cnt;
    w_err_nxt   = r_timeout_err;
    w_timeout   = 1'b0;
`endif
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_FETCH;
          w_test_nxt  = '0;
`ifdef TEST_SEQ_TIMEOUT_EN
          w_err_nxt   = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        w_data_nxt  = rom_data;
        w_state_nxt = S_DRIVE;
`ifdef TEST_SEQ_TIMEOUT_EN
        w_wd_nxt    = '0;
`endif
      end
      S_DRIVE: begin
        w_advance = w_hs;
`ifdef TEST_SEQ_TIMEOUT_EN
        // A handshake on the limit cycle wins over the watchdog
        if (!w_hs) begin
          if (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) w_timeout = 1'b1;
          else                                       w_wd_nxt  = r_wd_cnt + WD_W'(1);
        end
        w_advance = w_hs | w_timeout;
        w_err_nxt = r_timeout_err | w_timeout;
`endif
        if (w_advance) begin
          if (r_test == LAST_IDX) begin
            w_state_nxt = S_DONE;
          end else begin
            w_test_nxt = r_test + ADDR_WIDTH'(1);
            if (GAP_CYCLES > 0) begin
              w_gap_nxt   = GAP_W'(GAP_LOAD);
              w_state_nxt = S_GAP;
            end else begin
              w_state_nxt = S_FETCH;
            end
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == '0) w_state_nxt = S_FETCH;
        else                 w_gap_nxt   = r_gap_cnt - GAP_W'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs; valid/busy/done are decoded from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_test       <= '0;
      r_stim_data  <= '0;
      r_stim_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_gap_cnt    <= '0;
`ifdef TEST_SEQ_TIMEOUT_EN
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_test       <= w_test_nxt;
      r_stim_data  <= w_data_nxt;
      r_gap_cnt    <= w_gap_nxt;
      r_stim_valid <= (w_state_nxt == S_DRIVE);
      r_busy       <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_DRIVE) || (w_state_nxt == S_GAP);
      r_done       <= (w_state_nxt == S_DONE);
`ifdef TEST_SEQ_TIMEOUT_EN
      r_wd_cnt      <= w_wd_nxt;
      r_timeout_err <= w_err_nxt;
`endif
    end
  end

  assign rom_addr   = r_test;
  assign test       = r_test;
  assign stim_valid = r_stim_valid;
  assign stim_data  = r_stim_data;
  assign busy       = r_busy;
  assign done       = r_done;
`ifdef TEST_SEQ_TIMEOUT_EN
  assign timeout_err = r_timeout_err;
`endif

endmodule

// File: tb/tb_test_sequencer.sv
// Scoreboard bench for test_sequencer: a 3-vector/gap-2 instance and a 4-vector/gap-0 full-range instance.
module tb_test_sequencer;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start0;
  logic        stim_ready, ready0;
  logic [3:0]  rom_addr, test;
  logic [15:0] rom_data, stim_data;
  logic        stim_valid, busy, done;
  logic [1:0]  rom_addr0, test0;
  logic [15:0] rom_data0, stim_data0;
  logic        stim_valid0, busy0, done0;
`ifdef TEST_SEQ_TIMEOUT_EN
  logic        timeout_err, timeout_err0;
`endif

  logic [15:0] rom  [0:15];
  logic [15:0] rom0 [0:3];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  exp_t exp_q[$];
  exp_t exp0_q[$];
  int   hs_cyc[$];
  int   hs0_cyc[$];
  int   vlen_q[$];

  int          vrun = 0;
  logic        prev_valid = 1'b0, prev_hs = 1'b0;
  logic [15:0] prev_data = '0;
  logic [3:0]  prev_test = '0;
  exp_t        mon_e, mon0_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rom_data  = rom[rom_addr];
  assign rom_data0 = rom0[rom_addr0];

  test_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .NUM_TESTS(3), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) u_dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .stim_valid(stim_valid), .stim_data(stim_data), .stim_ready(stim_ready),
    .test(test), .busy(busy), .done(done)
`ifdef TEST_SEQ_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  test_sequencer #(.ADDR_WIDTH(2), .DATA_WIDTH(16), .NUM_TESTS(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(16)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .rom_addr(rom_addr0), .rom_data(rom_data0),
    .stim_valid(stim_valid0), .stim_data(stim_data0), .stim_ready(ready0),
    .test(test0), .busy(busy0), .done(done0)
`ifdef TEST_SEQ_TIMEOUT_EN
    , .timeout_err(timeout_err0)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic bit cond(input int code);
    case (code)
      0: return done;
      1: return done0;
      2: return stim_valid;
      3: return test == 4'd1;
      4: return test == 4'd2;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int code, input int max_cyc, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < max_cyc && !hit; i++) begin
      @(posedge clk);
      #1;
      hit = cond(code);
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL %s: not reached within %0d cycles, required within %0d", name, max_cyc, max_cyc);
    end
  endtask

  task automatic pulse_start(input int sel);
    @(posedge clk);
    #1;
    if (sel == 0) start = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start0 = 1'b0;
  endtask

  task automatic push3();
    exp_q.push_back('{data: 16'h1111, idx: 4'd0});
    exp_q.push_back('{data: 16'h2222, idx: 4'd1});
    exp_q.push_back('{data: 16'h3333, idx: 4'd2});
  endtask

  // Main-instance monitor: scoreboard pop on acceptance, stability and single-pulse checks
  always @(negedge clk) begin
    if (reset) begin
      vrun       = 0;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_hs) check("valid_after_accept", stim_valid, 0);
      if (stim_valid && prev_valid && !prev_hs) begin
        check("hold_data", stim_data, prev_data);
        check("hold_test", test, prev_test);
      end
      if (stim_valid) vrun++;
      else if (vrun != 0) begin
        vlen_q.push_back(vrun);
        vrun = 0;
      end
      if (stim_valid && stim_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_accept_data", stim_data, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("accept_data", stim_data, mon_e.data);
          check("accept_test", test, mon_e.idx);
        end
        hs_cyc.push_back(cyc);
      end
      prev_hs    = stim_valid && stim_ready;
      prev_valid = stim_valid;
      prev_data  = stim_data;
      prev_test  = test;
    end
  end

  // Gap-0 instance monitor
  always @(negedge clk) begin
    if (!reset && stim_valid0 && ready0) begin
      if (exp0_q.size() == 0) begin
        check("g0_unexpected_accept", stim_data0, 0);
      end else begin
        mon0_e = exp0_q.pop_front();
        check("g0_accept_data", stim_data0, mon0_e.data);
        check("g0_accept_test", test0, mon0_e.idx);
      end
      hs0_cyc.push_back(cyc);
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'h1111 * 16'(i + 1);
    for (int i = 0; i < 4; i++) rom0[i] = 16'hA000 + 16'(i);
    reset = 1'b1; start = 1'b0; start0 = 1'b0; stim_ready = 1'b0; ready0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", stim_valid, 0);
    check("rst_test", test, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_data", stim_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    stim_ready = 1'b1;

    // Free-running play with ready tied high
    push3();
    hs_cyc.delete();
    vlen_q.delete();
    pulse_start(0);
    check("t1_busy_after_start", busy, 1);
    wait_for(0, 60, "t1_done");
    check("t1_final_test", test, 2);
    check("t1_final_busy", busy, 0);
    check("t1_final_valid", stim_valid, 0);
    @(negedge clk);
    #1;
    check("t1_accept_count", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      check("t1_spacing_01", hs_cyc[1] - hs_cyc[0], 4);
      check("t1_spacing_12", hs_cyc[2] - hs_cyc[1], 4);
    end
    check("t1_pulse_count", vlen_q.size(), 3);
    foreach (vlen_q[i]) check("t1_pulse_len", vlen_q[i], 1);

    // Backpressure on test 1, start pulse during GAP is ignored, then restart from DONE
    push3();
    vlen_q.delete();
    pulse_start(0);
    check("t2_restart_done_low", done, 0);
    check("t2_restart_test", test, 0);
    wait_for(3, 20, "t2_reach_test1");
    check("t2_gap_valid", stim_valid, 0);
    check("t2_gap_busy", busy, 1);
    stim_ready = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_for(2, 20, "t2_drive_test1");
    repeat (5) @(posedge clk);
    #1;
    check("t2_stall_test", test, 1);
    check("t2_stall_data", stim_data, 16'h2222);
    stim_ready = 1'b1;
    wait_for(0, 60, "t2_done");
    @(negedge clk);
    #1;
    check("t2_pulse_count", vlen_q.size(), 3);
    if (vlen_q.size() == 3) begin
      check("t2_len0", vlen_q[0], 1);
      check("t2_len1", vlen_q[1], 6);
      check("t2_len2", vlen_q[2], 1);
    end

    // Asynchronous reset mid-DRIVE on test 2
    exp_q.push_back('{data: 16'h1111, idx: 4'd0});
    exp_q.push_back('{data: 16'h2222, idx: 4'd1});
    pulse_start(0);
    wait_for(4, 30, "t3_reach_test2");
    stim_ready = 1'b0;
    wait_for(2, 20, "t3_drive_test2");
    check("t3_pre_reset_valid", stim_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("t3_async_valid", stim_valid, 0);
    check("t3_async_test", test, 0);
    check("t3_async_busy", busy, 0);
    check("t3_async_done", done, 0);
    check("t3_scoreboard_drained", exp_q.size(), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    stim_ready = 1'b1;
    push3();
    pulse_start(0);
    wait_for(0, 60, "t3_done_after_reset");
    check("t3_final_test", test, 2);

`ifdef TEST_SEQ_TIMEOUT_EN
    // Watchdog: ready held low for every vector
    stim_ready = 1'b0;
    pulse_start(0);
    wait_for(2, 10, "to_drive0");
    repeat (15) @(posedge clk);
    #1;
    check("to_valid_at_limit", stim_valid, 1);
    check("to_err_before", timeout_err, 0);
    @(posedge clk);
    #1;
    check("to_valid_dropped", stim_valid, 0);
    check("to_err_set", timeout_err, 1);
    check("to_test_adv", test, 1);
    wait_for(0, 120, "to_done");
    check("to_err_in_done", timeout_err, 1);
    check("to_done_test", test, 2);
    stim_ready = 1'b1;
    push3();
    pulse_start(0);
    check("to_err_cleared", timeout_err, 0);
    wait_for(0, 60, "to_done_clean");
    check("to_err_clean_run", timeout_err, 0);
`endif

    // Gap-0, full index range
    for (int i = 0; i < 4; i++) exp0_q.push_back('{data: 16'hA000 + 16'(i), idx: 4'(i)});
    hs0_cyc.delete();
    pulse_start(1);
    wait_for(1, 40, "g0_done");
    check("g0_final_test", test0, 3);
    check("g0_final_addr", rom_addr0, 3);
    check("g0_final_busy", busy0, 0);
    check("g0_final_valid", stim_valid0, 0);
    check("g0_accept_count", hs0_cyc.size(), 4);
    if (hs0_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) check("g0_spacing", hs0_cyc[i] - hs0_cyc[i-1], 2);
    end
    repeat (3) @(posedge clk);
    #1;
    check("g0_no_wrap", test0, 3);
    check("g0_stays_done", done0, 1);

    check("sb_main_empty", exp_q.size(), 0);
    check("sb_gap0_empty", exp0_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
